// File: rtl/divide_bridge_if.sv
// Operand, result and core-handshake bundle for divide_bridge.
// The bridge uses the slave view; the clocked client plus the async core use the master view.
interface divide_bridge_if #(
  parameter int AWidth = 32,
  parameter int BWidth = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [AWidth-1:0] in_a;
  logic [BWidth-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [AWidth-1:0] out_q;
  logic [BWidth-1:0] out_r;
  logic              out_dz;
  logic              out_to;
  logic              div_req;
  logic              div_fin;
  logic [AWidth-1:0] div_a;
  logic [BWidth-1:0] div_b;
  logic [AWidth-1:0] div_s;
  logic [BWidth-1:0] div_mod;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, div_fin, div_s, div_mod,
    output in_ready, out_valid, out_q, out_r, out_dz, out_to, div_req, div_a, div_b
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, div_fin, div_s, div_mod,
    input  in_ready, out_valid, out_q, out_r, out_dz, out_to, div_req, div_a, div_b
  );
endinterface

// File: rtl/divide_bridge.sv
// Clocked valid/ready front-end for the self-timed divide core: runs the four-phase
// req/fin handshake through a fin synchronizer, short-circuits x/0 and aborts on a dead core.
module divide_bridge #(
  parameter int AWidth  = 32,
  parameter int BWidth  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  divide_bridge_if.slave  bus
);
  localparam int CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam int MaxW = (AWidth > BWidth) ? AWidth : BWidth;

  typedef enum logic [1:0] {IDLE, REQ, RTZ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [AWidth-1:0] a_q, a_d;
  logic [BWidth-1:0] b_q, b_d;
  logic [AWidth-1:0] quot_q, quot_d;
  logic [BWidth-1:0] rem_q, rem_d;
  logic              dz_q, dz_d;
  logic              to_q, to_d;
  logic              finMeta_q, finSync_q;
  logic [1:0]        warm_q;
  logic              inReady;
  logic [MaxW-1:0]   aExt;
  logic [BWidth-1:0] dzRem;

  // warm_q holds off acceptance until the sync flops carry real samples of fin,
  // so a fin left high across reset is seen before any new request is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      finMeta_q <= 1'b0;
      finSync_q <= 1'b0;
      warm_q    <= 2'd0;
    end else begin
      finMeta_q <= bus.div_fin;
      finSync_q <= finMeta_q;
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
    end
  end

  assign inReady = (state_q == IDLE) && !finSync_q && (warm_q == 2'd2) && !rst;
  assign aExt    = MaxW'(bus.in_a);
  assign dzRem   = aExt[BWidth-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && inReady) begin
          if (bus.in_b != '0) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            quot_d  = '1;
            rem_d   = dzRem;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (finSync_q) begin
          quot_d  = bus.div_s;
          rem_d   = bus.div_mod;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = RTZ;
        end else if (cnt_q == CntLast) begin
          quot_d  = '0;
          rem_d   = '0;
          to_d    = 1'b1;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = RTZ;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RTZ: begin
        // A late return-to-zero keeps whatever result was captured and only flags it.
        if (!finSync_q) begin
          state_d = DONE;
        end else if (cnt_q == CntLast) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          dz_d    = 1'b0;
          to_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_q     = quot_q;
  assign bus.out_r     = rem_q;
  assign bus.out_dz    = dz_q;
  assign bus.out_to    = to_q;
  assign bus.div_req   = req_q;
  assign bus.div_a     = a_q;
  assign bus.div_b     = b_q;
endmodule

// File: tb/tb_divide_bridge.sv
// Self-checking bench for divide_bridge: vector table plus hand-timed sequences,
// with a behavioural async core and a result scoreboard checked on every cycle.
module tb_divide_bridge;
  localparam int AW = 32;
  localparam int BW = 32;
  localparam int TO = 16;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        to;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          delay;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  logic        coreAuto;
  logic        coreFin;
  logic [31:0] coreS, coreMod;
  logic        manFin;
  logic [31:0] manS, manMod;
  int          coreDelay;

  always #5 clk = ~clk;

  divide_bridge_if #(.AWidth(AW), .BWidth(BW)) bus ();

  divide_bridge #(.AWidth(AW), .BWidth(BW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.div_fin = coreAuto ? coreFin : manFin;
  assign bus.div_s   = coreAuto ? coreS   : manS;
  assign bus.div_mod = coreAuto ? coreMod : manMod;

  // Behavioural self-timed core: answers req after coreDelay cycles, then returns to zero.
  initial begin
    coreFin = 1'b0;
    coreS   = '0;
    coreMod = '0;
    forever begin
      @(negedge clk);
      if (coreAuto && bus.div_req === 1'b1 && !coreFin) begin
        repeat (coreDelay) @(negedge clk);
        coreS   = bus.div_a / bus.div_b;
        coreMod = bus.div_a % bus.div_b;
        coreFin = 1'b1;
      end else if (coreAuto && bus.div_req === 1'b0 && coreFin) begin
        repeat (coreDelay) @(negedge clk);
        coreFin = 1'b0;
      end
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard sample happens before each edge so out_ready matches what the DUT sees.
  task automatic tick();
    res_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_out_valid: got result q=0x%0h with nothing outstanding", bus.out_q);
      end else begin
        e = sb.pop_front();
        check("out_q", bus.out_q, e.q);
        check("out_r", bus.out_r, e.r);
        check("out_dz", 32'(bus.out_dz), 32'(e.dz));
        check("out_to", 32'(bus.out_to), 32'(e.to));
      end
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input res_t exp, input bit expectResult);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready got %b, expected 1 within 100 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    if (expectResult) sb.push_back(exp);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input int maxCycles);
    int n = 0;
    while (sb.size() != 0 && n < maxCycles) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    res_t r;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0};
    vecs[1] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 2};
    vecs[2] = '{32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0};
    vecs[3] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3};
    vecs[5] = '{32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0, 0};
    vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 4};
    vecs[7] = '{32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, 5};
    vecs[8] = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 0};
    vecs[9] = '{32'd3, 32'd4, 32'd0, 32'd3, 1'b0, 1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    coreAuto = 1'b1;
    coreDelay = 1;
    manFin = 1'b0;
    manS = '0;
    manMod = '0;

    repeat (3) tick();
    check("rst_div_req", 32'(bus.div_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_q", bus.out_q, 32'd0);
    check("rst_out_r", bus.out_r, 32'd0);
    check("rst_div_a", bus.div_a, 32'd0);
    check("rst_div_b", bus.div_b, 32'd0);
    check("rst_flags", {30'd0, bus.out_dz, bus.out_to}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table-driven vectors through the auto core
    for (int i = 0; i < 10; i++) begin
      coreDelay = vecs[i].delay;
      r = '{vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0};
      applyStimulus(vecs[i].a, vecs[i].b, r, 1'b1);
      checkOutput(100);
    end
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 1000);
      coreDelay = i;
      r = '{ra / rb, ra % rb, 1'b0, 1'b0};
      applyStimulus(ra, rb, r, 1'b1);
      checkOutput(100);
    end

    // Hand-timed handshake for 100/7
    coreAuto = 1'b0;
    applyStimulus(32'd100, 32'd7, '{32'd14, 32'd2, 1'b0, 1'b0}, 1'b1);
    check("req_after_accept", 32'(bus.div_req), 32'd1);
    check("div_a_latched", bus.div_a, 32'd100);
    check("div_b_latched", bus.div_b, 32'd7);
    tick();
    manS = 32'd14;
    manMod = 32'd2;
    manFin = 1'b1;
    tick();
    check("req_after_F", 32'(bus.div_req), 32'd1);
    tick();
    check("req_after_F1", 32'(bus.div_req), 32'd1);
    tick();
    check("req_after_F2", 32'(bus.div_req), 32'd0);
    manFin = 1'b0;
    tick();
    check("valid_after_G", 32'(bus.out_valid), 32'd0);
    tick();
    check("valid_after_G1", 32'(bus.out_valid), 32'd0);
    tick();
    check("valid_after_G2", 32'(bus.out_valid), 32'd1);
    checkOutput(10);
    coreAuto = 1'b1;

    // Divide-by-zero has one cycle of latency and never touches the core
    applyStimulus(32'h1234, 32'd0, '{32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0}, 1'b1);
    check("dz_valid_latency", 32'(bus.out_valid), 32'd1);
    check("dz_no_req", 32'(bus.div_req), 32'd0);
    checkOutput(10);

    // Back-pressure with bundled-data stability while req is high
    bus.out_ready = 1'b0;
    coreDelay = 3;
    applyStimulus(32'd5, 32'd9, '{32'd0, 32'd5, 1'b0, 1'b0}, 1'b1);
    for (int n = 0; n < 100 && bus.out_valid !== 1'b1; n++) begin
      if (bus.div_req === 1'b1) begin
        check("bundle_div_a", bus.div_a, 32'd5);
        check("bundle_div_b", bus.div_b, 32'd9);
      end
      tick();
    end
    check("bp_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int n = 0; n < 10; n++) begin
      tick();
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_q", bus.out_q, 32'd0);
      check("bp_hold_r", bus.out_r, 32'd5);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    checkOutput(5);

    // Dead core: req drops after TO cycles in REQ, then a timeout result
    coreAuto = 1'b0;
    manFin = 1'b0;
    applyStimulus(32'd50, 32'd3, '{32'd0, 32'd0, 1'b0, 1'b1}, 1'b1);
    for (int i = 1; i <= TO; i++) begin
      tick();
      check("to_req_window", 32'(bus.div_req), (i < TO) ? 32'd1 : 32'd0);
    end
    tick();
    check("to_valid", 32'(bus.out_valid), 32'd1);
    checkOutput(10);

    // Reset mid-operation with fin stuck high across reset
    applyStimulus(32'd100, 32'd7, '{32'd0, 32'd0, 1'b0, 1'b0}, 1'b0);
    check("mid_req_high", 32'(bus.div_req), 32'd1);
    manS = 32'd14;
    manMod = 32'd2;
    manFin = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_req_drop", 32'(bus.div_req), 32'd0);
    tick();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      check("stale_fin_in_ready", 32'(bus.in_ready), 32'd0);
    end
    manFin = 1'b0;
    tick();
    check("fin_low_G_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("fin_low_G1_in_ready", 32'(bus.in_ready), 32'd1);
    coreAuto = 1'b1;
    coreDelay = 1;
    applyStimulus(32'd9, 32'd4, '{32'd2, 32'd1, 1'b0, 1'b0}, 1'b1);
    checkOutput(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divide_bridge.md
# divide_bridge

Synchronous front-end for the self-timed `divide` core. It accepts operands on a clocked valid/ready interface, drives the core's `req`/`fin` four-phase handshake through a two-flop synchronizer, and captures quotient and remainder. It returns them on a clocked valid/ready output. It also short-circuits divide-by-zero and recovers from a core that stops responding, so clocked datapaths can use the divider without handling asynchronous timing.

## Interface
- `AWidth`, 32, width of dividend and quotient
- `BWidth`, 32, width of divisor and remainder
- `TIMEOUT`, 4096, max cycles spent in each handshake phase before abort (≥4)

One clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  bridge can accept operands
- `in_a`  in  AWidth  dividend
- `in_b`  in  BWidth  divisor
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_q`  out  AWidth  quotient
- `out_r`  out  BWidth  remainder
- `out_dz`  out  1  divide-by-zero flag
- `out_to`  out  1  timeout flag
- `div_req`  out  1  to core `req`, registered
- `div_fin`  in  1  from core `fin`, asynchronous
- `div_a`  out  AWidth  to core `a`, registered
- `div_b`  out  BWidth  to core `b`, registered
- `div_s`  in  AWidth  core quotient
- `div_mod`  in  BWidth  core remainder

## Operation
- `fin_s`: `div_fin` passed through 2 flops, both reset to 0. All core-side decisions use `fin_s` only.
- States: IDLE, REQ, RTZ, DONE.
- `in_ready` = (state==IDLE) && !fin_s && !rst. Only one operation is outstanding at a time.
- IDLE, on `in_valid && in_ready`:
  - `in_b`≠0: latch `div_a`/`div_b`, set `div_req`=1, clear the counter, go to REQ.
  - `in_b`==0: `out_q`=all ones, `out_r`=`in_a[BWidth-1:0]` (zero-extended if AWidth<BWidth), `out_dz`=1, go to DONE. `div_req` stays 0.
- REQ:
  - `fin_s`==1: capture `out_q`←`div_s`, `out_r`←`div_mod`, set `div_req`=0, clear the counter, go to RTZ. Core data is bundled and stable for ≥2 cycles by this point.
  - Counter reaches TIMEOUT−1: set `div_req`=0, `out_q`=0, `out_r`=0, `out_to`=1, clear the counter, go to RTZ.
- RTZ:
  - `fin_s`==0: go to DONE.
  - Counter reaches TIMEOUT−1: set `out_to`=1, go to DONE. The result fields already captured are kept.
- DONE:
  - `out_valid`=1. `out_q`/`out_r`/`out_dz`/`out_to` are held stable until `out_ready`.
  - On handshake, clear the flags and go to IDLE.
- `div_a`/`div_b` are held constant from REQ entry until the next accept. Bundled-data rule: they never change while `div_req`=1.

## Timing
- Reset values:
  - State IDLE.
  - `div_req`, `out_valid`, `out_dz`, `out_to` = 0.
  - `out_q`, `out_r`, `div_a`, `div_b` = 0.
  - Counter and sync flops = 0.
- Accept at edge N → `div_req`=1 after edge N.
- Core `fin` rises before edge F → `fin_s`=1 after F+1 → capture and `div_req`=0 after F+2.
- Core `fin` falls before edge G → `out_valid`=1 after G+2.
- Divide-by-zero: accept at edge N → `out_valid`=1 after N, i.e. one cycle of latency.
- `out_valid && out_ready` at edge M → `in_ready`=1 after M, provided `fin_s`=0. No same-cycle turnaround.
- Reset mid-operation:
  - `div_req` drops on the reset edge and the in-flight result is discarded.
  - After reset, `in_ready` stays 0 until the core's `fin` is seen low, so a stale `fin` never completes a new request.
- The counter saturates and does not wrap. It counts only in REQ and RTZ.

## Test plan
- `in_a`=100, `in_b`=7, core model responds correctly → `out_q`=14, `out_r`=2, `out_dz`=0, `out_to`=0. `div_req` rises 1 cycle after accept and falls 2 cycles after `fin` rises.
- `in_a`=5, `in_b`=9 → `out_q`=0, `out_r`=5. `div_a`/`div_b` remain stable throughout `div_req` high.
- `in_a`=0x1234, `in_b`=0 → `out_valid` 1 cycle after accept, `out_q`=0xFFFFFFFF, `out_r`=0x1234, `out_dz`=1, `div_req` never asserts.
- Hold `out_ready`=0 for 10 cycles after a result → `out_valid` and data stay constant and `in_ready`=0. Then `out_ready`=1 → `in_ready`=1 next cycle.
- Core `fin` stuck at 0 with TIMEOUT=16 → `div_req` drops after 16 cycles in REQ, then `out_valid` with `out_to`=1, `out_q`=0, `out_r`=0.
- Assert `rst` while `div_req`=1 and `fin`=1; release `rst` with `fin` still 1 → `in_ready`=0 until `fin` falls, then `in_ready`=1 two cycles later. No spurious `out_valid` occurs.
